// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing data_memory between the core MEM stage and the loader.
// Optional: define ARB_PERF_COUNTERS_EN to add stall / loader-grant performance counters.
module data_memory_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_wren,
    input  logic [ADDR_W-1:0] core_address,
    input  logic [DATA_W-1:0] core_data,
    input  logic [3:0]        core_byteena,
    output logic              core_stall,
    output logic              core_rvalid,
    input  logic              loader_req,
    input  logic              loader_lock,
    input  logic              loader_wren,
    input  logic [ADDR_W-1:0] loader_address,
    input  logic [DATA_W-1:0] loader_data,
    input  logic [3:0]        loader_byteena,
    output logic              loader_gnt,
    output logic              loader_rvalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [3:0]        mem_byteena,
`ifdef ARB_PERF_COUNTERS_EN
    output logic [31:0]       perf_core_stall,
    output logic [31:0]       perf_loader_gnt,
`endif
    output logic [7:0]        pending_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] WAIT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LOAD = 2'd2,
        LOCKED   = 2'd3
    } owner_e;

    owner_e           state, state_next;
    logic             last_owner_load, last_owner_load_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             core_gnt;
    logic             force_core;

    // State register, wait counter and read-return pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= OWN_NONE;
            last_owner_load <= 1'b1;
            wait_cnt        <= '0;
            core_rvalid     <= 1'b0;
            loader_rvalid   <= 1'b0;
        end else begin
            state           <= state_next;
            last_owner_load <= last_owner_load_next;
            wait_cnt        <= wait_cnt_next;
            core_rvalid     <= core_gnt && !core_wren;
            loader_rvalid   <= loader_gnt && !loader_wren;
        end
    end

    // Grant decision, owner FSM and wait-count update
    always_comb begin
        core_gnt             = 1'b0;
        loader_gnt           = 1'b0;
        state_next           = state;
        last_owner_load_next = last_owner_load;
        wait_cnt_next        = wait_cnt;

        force_core = core_req && (wait_cnt == WAIT_LIMIT);

        if (force_core) begin
            core_gnt = 1'b1;
        end else if (state == LOCKED && loader_req) begin
            loader_gnt = 1'b1;
        end else if (core_req && loader_req) begin
            core_gnt   = last_owner_load;
            loader_gnt = !last_owner_load;
        end else begin
            core_gnt   = core_req;
            loader_gnt = loader_req;
        end

        // Only contended cycles move the round-robin pointer
        if (core_req && loader_req) begin
            last_owner_load_next = loader_gnt;
        end

        if (core_gnt) begin
            state_next = OWN_CORE;
        end else if (loader_gnt) begin
            state_next = loader_lock ? LOCKED : OWN_LOAD;
        end else if (state == LOCKED) begin
            state_next = OWN_LOAD;
        end

        if (!core_req || core_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // Memory port mux; core values hold the bus when idle
    always_comb begin
        mem_address = core_address;
        mem_data    = core_data;
        mem_wren    = 1'b0;
        mem_byteena = 4'b0000;
        if (loader_gnt) begin
            mem_address = loader_address;
            mem_data    = loader_data;
            mem_wren    = loader_wren;
            mem_byteena = loader_byteena;
        end else if (core_gnt) begin
            mem_wren    = core_wren;
            mem_byteena = core_byteena;
        end
    end

    assign core_stall  = core_req && !core_gnt;
    assign pending_cnt = wait_cnt;

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] core_stall_cycles;
    logic [31:0] loader_grant_cycles;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_stall_cycles   <= '0;
            loader_grant_cycles <= '0;
        end else begin
            if (core_stall) core_stall_cycles   <= core_stall_cycles + 32'(1);
            if (loader_gnt) loader_grant_cycles <= loader_grant_cycles + 32'(1);
        end
    end

    assign perf_core_stall = core_stall_cycles;
    assign perf_loader_gnt = loader_grant_cycles;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a one-cycle-latency memory model.
module tb_data_memory_arbiter;

    logic        clock;
    logic        reset;
    logic        core_req, core_wren;
    logic [11:0] core_address;
    logic [31:0] core_data;
    logic [3:0]  core_byteena;
    logic        core_stall, core_rvalid;
    logic        loader_req, loader_lock, loader_wren;
    logic [11:0] loader_address;
    logic [31:0] loader_data;
    logic [3:0]  loader_byteena;
    logic        loader_gnt, loader_rvalid;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [3:0]  mem_byteena;
    logic [7:0]  pending_cnt;
`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] perf_core_stall, perf_loader_gnt;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] mem_q;

    data_memory_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_wren(core_wren), .core_address(core_address),
        .core_data(core_data), .core_byteena(core_byteena),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .loader_req(loader_req), .loader_lock(loader_lock), .loader_wren(loader_wren),
        .loader_address(loader_address), .loader_data(loader_data),
        .loader_byteena(loader_byteena),
        .loader_gnt(loader_gnt), .loader_rvalid(loader_rvalid),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_byteena(mem_byteena),
`ifdef ARB_PERF_COUNTERS_EN
        .perf_core_stall(perf_core_stall), .perf_loader_gnt(perf_loader_gnt),
`endif
        .pending_cnt(pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-enabled single-port memory with registered read data
    always @(posedge clock) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
        end
        mem_q <= mem[mem_address];
    end

    task automatic idle_inputs();
        core_req = 0; core_wren = 0; core_address = 12'h000; core_data = 32'h0;
        core_byteena = 4'hF;
        loader_req = 0; loader_lock = 0; loader_wren = 0; loader_address = 12'h000;
        loader_data = 32'h0; loader_byteena = 4'hF;
    endtask

    task automatic apply_reset();
        reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        apply_reset();
        @(negedge clock);
        check_cnt++;
        if (core_rvalid !== 1'b0 || loader_rvalid !== 1'b0)
            $display("FAIL reset_rvalid: got c=%0b l=%0b want 0 0", core_rvalid, loader_rvalid);
        else pass_cnt++;
        check_cnt++;
        if (pending_cnt !== 8'd0) $display("FAIL reset_pending: got %0d want 0", pending_cnt);
        else pass_cnt++;
        check_cnt++;
        if (mem_wren !== 1'b0 || mem_byteena !== 4'h0 || loader_gnt !== 1'b0)
            $display("FAIL reset_idle_bus: got wren=%0b be=%0h lg=%0b want 0 0 0",
                     mem_wren, mem_byteena, loader_gnt);
        else pass_cnt++;
    endtask

    task automatic test_core_only();
        @(posedge clock); #1;
        core_req = 1; core_wren = 0; core_address = 12'h010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_cnt++;
            if (core_stall !== 1'b0 || mem_address !== 12'h010 || mem_byteena !== 4'hF)
                $display("FAIL core_only_grant[%0d]: got stall=%0b addr=%0h be=%0h want 0 010 f",
                         i, core_stall, mem_address, mem_byteena);
            else pass_cnt++;
            @(posedge clock); #1;
            check_cnt++;
            if (core_rvalid !== 1'b1) $display("FAIL core_only_rvalid[%0d]: got %0b want 1", i, core_rvalid);
            else pass_cnt++;
        end
        core_req = 0;
        @(posedge clock); #1;
        check_cnt++;
        if (core_rvalid !== 1'b0) $display("FAIL core_only_rvalid_drop: got %0b want 0", core_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_alternate();
        core_req = 1; core_address = 12'h030; loader_req = 1; loader_lock = 0;
        loader_address = 12'h040;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_cnt++;
            if (loader_gnt !== (i % 2 == 1) || core_stall !== (i % 2 == 1))
                $display("FAIL alternate[%0d]: got lgnt=%0b stall=%0b want %0b %0b",
                         i, loader_gnt, core_stall, (i % 2 == 1), (i % 2 == 1));
            else pass_cnt++;
            check_cnt++;
            if (mem_address !== ((i % 2 == 1) ? 12'h040 : 12'h030))
                $display("FAIL alternate_addr[%0d]: got %0h want %0h", i, mem_address,
                         ((i % 2 == 1) ? 12'h040 : 12'h030));
            else pass_cnt++;
            @(posedge clock); #1;
        end
        idle_inputs();
        @(posedge clock); #1;
    endtask

    task automatic test_starvation();
        loader_req = 1; loader_lock = 1; loader_address = 12'h050;
        @(negedge clock);
        check_cnt++;
        if (loader_gnt !== 1'b1) $display("FAIL lock_entry: got %0b want 1", loader_gnt);
        else pass_cnt++;
        @(posedge clock); #1;
        core_req = 1; core_address = 12'h060;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            check_cnt++;
            if (pending_cnt !== 8'(k)) $display("FAIL starve_pending[%0d]: got %0d want %0d", k, pending_cnt, k);
            else pass_cnt++;
            check_cnt++;
            if (loader_gnt !== (k < 8) || core_stall !== (k < 8))
                $display("FAIL starve_grant[%0d]: got lgnt=%0b stall=%0b want %0b %0b",
                         k, loader_gnt, core_stall, (k < 8), (k < 8));
            else pass_cnt++;
            @(posedge clock); #1;
        end
        check_cnt++;
        if (pending_cnt !== 8'd0) $display("FAIL starve_clear: got %0d want 0", pending_cnt);
        else pass_cnt++;
        idle_inputs();
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        loader_req = 1; loader_wren = 1; loader_address = 12'h020; loader_data = 32'hDEADBEEF;
        @(negedge clock);
        check_cnt++;
        if (loader_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_address !== 12'h020 || mem_data !== 32'hDEADBEEF)
            $display("FAIL ld_write: got gnt=%0b wren=%0b addr=%0h data=%0h want 1 1 020 deadbeef",
                     loader_gnt, mem_wren, mem_address, mem_data);
        else pass_cnt++;
        @(posedge clock); #1;
        check_cnt++;
        if (loader_rvalid !== 1'b0) $display("FAIL ld_write_rvalid: got %0b want 0", loader_rvalid);
        else pass_cnt++;
        idle_inputs();
        core_req = 1; core_address = 12'h020;
        @(negedge clock);
        check_cnt++;
        if (mem_wren !== 1'b0 || core_stall !== 1'b0 || mem_address !== 12'h020)
            $display("FAIL core_read: got wren=%0b stall=%0b addr=%0h want 0 0 020",
                     mem_wren, core_stall, mem_address);
        else pass_cnt++;
        @(posedge clock); #1;
        core_req = 0;
        check_cnt++;
        if (core_rvalid !== 1'b1 || mem_q !== 32'hDEADBEEF)
            $display("FAIL core_read_data: got rvalid=%0b q=%0h want 1 deadbeef", core_rvalid, mem_q);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_lock();
        loader_req = 1; loader_lock = 1; loader_wren = 0; loader_address = 12'h070;
        @(posedge clock); #1;
        @(negedge clock);
        check_cnt++;
        if (loader_gnt !== 1'b1) $display("FAIL mid_lock_gnt: got %0b want 1", loader_gnt);
        else pass_cnt++;
        #2 reset = 0;
        @(posedge clock); #1;
        check_cnt++;
        if (loader_rvalid !== 1'b0 || core_rvalid !== 1'b0 || pending_cnt !== 8'd0)
            $display("FAIL mid_reset_state: got lrv=%0b crv=%0b pend=%0d want 0 0 0",
                     loader_rvalid, core_rvalid, pending_cnt);
        else pass_cnt++;
        core_req = 1; core_address = 12'h080;
        reset = 1;
        @(negedge clock);
        check_cnt++;
        if (loader_gnt !== 1'b0 || core_stall !== 1'b0)
            $display("FAIL post_reset_tie: got lgnt=%0b stall=%0b want 0 0", loader_gnt, core_stall);
        else pass_cnt++;
        @(posedge clock); #1;
        idle_inputs();
        @(posedge clock); #1;
    endtask

`ifdef ARB_PERF_COUNTERS_EN
    task automatic test_perf();
        apply_reset();
        core_req = 1; loader_req = 1;
        repeat (10) @(posedge clock);
        #1 idle_inputs();
        check_cnt++;
        if (perf_core_stall !== 32'd5 || perf_loader_gnt !== 32'd5)
            $display("FAIL perf_counters: got stall=%0d lgnt=%0d want 5 5", perf_core_stall, perf_loader_gnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_core_only();
        test_alternate();
        test_starvation();
        test_write_read();
        test_reset_mid_lock();
`ifdef ARB_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
